// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the 640x480@60 VGA path.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned H_VIS  = 640;
    localparam int unsigned H_FP   = 16;
    localparam int unsigned H_SYNC = 96;
    localparam int unsigned H_BP   = 48;
    localparam int unsigned V_VIS  = 480;
    localparam int unsigned V_FP   = 10;
    localparam int unsigned V_SYNC = 2;
    localparam int unsigned V_BP   = 33;

    localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_VIS + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VIS + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    function automatic logic in_window(input logic [CNT_W-1:0] x,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (x >= lo) && (x < hi);
    endfunction

endpackage

// File: rtl/pix_tick_div.sv
// Pixel-rate enable: one-clk tick every CLK_DIV system clocks.
module pix_tick_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    assign tick = (div == DIV_MAX);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing source: h/v counters, registered sync/valid, per-frame score latch.
// Optional FRAME_CNT_EN adds a 16-bit frame counter output.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned H_VIS   = vga_timing_pkg::H_VIS,
    parameter int unsigned H_FP    = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC  = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP    = vga_timing_pkg::H_BP,
    parameter int unsigned V_VIS   = vga_timing_pkg::V_VIS,
    parameter int unsigned V_FP    = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC  = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP    = vga_timing_pkg::V_BP
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [3:0]                      score0_in,
    input  logic [3:0]                      score1_in,
    output logic [vga_timing_pkg::CNT_W-1:0] h_cnt,
    output logic [vga_timing_pkg::CNT_W-1:0] v_cnt,
    output logic                            valid,
    output logic                            hsync,
    output logic                            vsync,
    output logic [3:0]                      score0,
    output logic [3:0]                      score1,
`ifdef FRAME_CNT_EN
    output logic [15:0]                     frame_cnt,
`endif
    output logic                            frame_start
);

    import vga_timing_pkg::*;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_VIS_L = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_L = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] HS_LO   = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_HI   = CNT_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_LO   = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_HI   = CNT_W'(V_VIS + V_FP + V_SYNC);

    logic             tick;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             at_origin;
    logic             at_blank;

    pix_tick_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    always_comb begin
        h_nxt = h_cnt + CNT_W'(1);
        v_nxt = v_cnt;
        if (h_cnt == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
        end
        at_origin = (h_nxt == '0) && (v_nxt == '0);
        at_blank  = (h_nxt == '0) && (v_nxt == V_VIS_L);
    end

    // Flags are derived from the next counter values so they line up with h_cnt/v_cnt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt       <= H_LAST;
            v_cnt       <= V_LAST;
            valid       <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            score0      <= '0;
            score1      <= '0;
            frame_start <= 1'b0;
`ifdef FRAME_CNT_EN
            frame_cnt   <= '0;
`endif
        end else begin
            frame_start <= 1'b0;
            if (tick) begin
                h_cnt       <= h_nxt;
                v_cnt       <= v_nxt;
                valid       <= (h_nxt < H_VIS_L) && (v_nxt < V_VIS_L);
                hsync       <= !in_window(h_nxt, HS_LO, HS_HI);
                vsync       <= !in_window(v_nxt, VS_LO, VS_HI);
                frame_start <= at_origin;
                if (at_blank) begin
                    score0 <= score0_in;
                    score1 <= score1_in;
                end
`ifdef FRAME_CNT_EN
                if (at_origin) begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a reduced-geometry instance (A) and a default instance (B).
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] score0_in = '0;
    logic [3:0] score1_in = '0;

    logic [9:0] a_h, a_v, b_h, b_v;
    logic       a_val, a_hs, a_vs, a_fs, b_val, b_hs, b_vs, b_fs;
    logic [3:0] a_s0, a_s1, b_s0, b_s1;
`ifdef FRAME_CNT_EN
    logic [15:0] a_fc, b_fc;
`endif

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV(4), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .score0_in(score0_in), .score1_in(score1_in),
        .h_cnt(a_h), .v_cnt(a_v), .valid(a_val), .hsync(a_hs), .vsync(a_vs),
        .score0(a_s0), .score1(a_s1),
`ifdef FRAME_CNT_EN
        .frame_cnt(a_fc),
`endif
        .frame_start(a_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(1)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .score0_in(score0_in), .score1_in(score1_in),
        .h_cnt(b_h), .v_cnt(b_v), .valid(b_val), .hsync(b_hs), .vsync(b_vs),
        .score0(b_s0), .score1(b_s1),
`ifdef FRAME_CNT_EN
        .frame_cnt(b_fc),
`endif
        .frame_start(b_fs)
    );

    // Geometry of each instance: index 0 = A, 1 = B.
    int unsigned p_div[2]  = '{4, 1};
    int unsigned p_hvis[2] = '{8, 640};
    int unsigned p_hfp[2]  = '{2, 16};
    int unsigned p_hsy[2]  = '{3, 96};
    int unsigned p_ht[2]   = '{15, 800};
    int unsigned p_vvis[2] = '{6, 480};
    int unsigned p_vfp[2]  = '{2, 10};
    int unsigned p_vsy[2]  = '{2, 2};
    int unsigned p_vt[2]   = '{12, 525};

    longint unsigned m_clks[2];
    longint unsigned m_ticks[2];
    logic            m_fs[2];
    logic [3:0]      m_s0[2];
    logic [3:0]      m_s1[2];
    int unsigned     m_fc[2];

    // Position is a pure function of pixel ticks since reset.
    function automatic void model_pos(input int d, input longint unsigned t,
                                      output int unsigned h, output int unsigned v);
        longint unsigned idx;
        if (t == 0) begin
            h = p_ht[d] - 1;
            v = p_vt[d] - 1;
        end else begin
            idx = (t - 1) % (p_ht[d] * p_vt[d]);
            h = int'(idx % p_ht[d]);
            v = int'(idx / p_ht[d]);
        end
    endfunction

    always @(posedge clk) begin
        int unsigned h, v;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_clks[d] = 0; m_ticks[d] = 0; m_fs[d] = 1'b0;
                m_s0[d] = '0; m_s1[d] = '0; m_fc[d] = 0;
            end else begin
                m_clks[d]++;
                m_fs[d] = 1'b0;
                if (m_clks[d] % p_div[d] == 0) begin
                    m_ticks[d]++;
                    model_pos(d, m_ticks[d], h, v);
                    if (h == 0 && v == 0) begin
                        m_fs[d] = 1'b1;
                        m_fc[d] = (m_fc[d] + 1) % 65536;
                    end
                    if (h == 0 && v == p_vvis[d]) begin
                        m_s0[d] = score0_in;
                        m_s1[d] = score1_in;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input int d, input logic [9:0] h, input logic [9:0] v,
                           input logic val, input logic hs, input logic vs, input logic fs,
                           input logic [3:0] s0, input logic [3:0] s1);
        int unsigned eh, ev;
        model_pos(d, m_ticks[d], eh, ev);
        chk($sformatf("d%0d h_cnt", d), int'(h), int'(eh));
        chk($sformatf("d%0d v_cnt", d), int'(v), int'(ev));
        chk($sformatf("d%0d valid", d), int'(val), int'(eh < p_hvis[d] && ev < p_vvis[d]));
        chk($sformatf("d%0d hsync", d), int'(hs),
            int'(!(eh >= p_hvis[d] + p_hfp[d] && eh < p_hvis[d] + p_hfp[d] + p_hsy[d])));
        chk($sformatf("d%0d vsync", d), int'(vs),
            int'(!(ev >= p_vvis[d] + p_vfp[d] && ev < p_vvis[d] + p_vfp[d] + p_vsy[d])));
        chk($sformatf("d%0d frame_start", d), int'(fs), int'(m_fs[d]));
        chk($sformatf("d%0d score0", d), int'(s0), int'(m_s0[d]));
        chk($sformatf("d%0d score1", d), int'(s1), int'(m_s1[d]));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut(0, a_h, a_v, a_val, a_hs, a_vs, a_fs, a_s0, a_s1);
            cmp_dut(1, b_h, b_v, b_val, b_hs, b_vs, b_fs, b_s0, b_s1);
`ifdef FRAME_CNT_EN
            chk("d0 frame_cnt", int'(a_fc), int'(m_fc[0]));
            chk("d1 frame_cnt", int'(b_fc), int'(m_fc[1]));
`endif
        end
    end

    task automatic wait_a(input int h, input int v, input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (int'(a_h) == h && int'(a_v) == v) return;
        end
        chk({"timeout ", tag}, 0, 1);
    endtask

    task automatic wait_b(input int h, input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (int'(b_h) == h) return;
        end
        chk({"timeout ", tag}, 0, 1);
    endtask

    task automatic reset_release(input int n);
        rst_n = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int gap;
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst h", int'(a_h), 14);
        chk("rst v", int'(a_v), 11);
        chk("rst valid", int'(a_val), 0);
        chk("rst hsync", int'(a_hs), 1);
        chk("rst vsync", int'(a_vs), 1);
        chk("rst b_h", int'(b_h), 799);
        chk("rst b_v", int'(b_v), 524);
        reset_release(4);

        // Start-up latency
        @(negedge clk);
        chk("b first h", int'(b_h), 0);
        chk("b first fs", int'(b_fs), 1);
        chk("b first valid", int'(b_val), 1);
        chk("a hold1", int'(a_h), 14);
        @(negedge clk);
        chk("b second fs", int'(b_fs), 0);
        chk("b second h", int'(b_h), 1);
        chk("a hold2 valid", int'(a_val), 0);
        @(negedge clk);
        chk("a hold3 v", int'(a_v), 11);
        @(negedge clk);
        chk("a first h", int'(a_h), 0);
        chk("a first v", int'(a_v), 0);
        chk("a first fs", int'(a_fs), 1);
        chk("a first valid", int'(a_val), 1);
        @(negedge clk);
        chk("a fs width", int'(a_fs), 0);
        repeat (3) @(negedge clk);
        chk("a h after 4", int'(a_h), 1);

        // Default line geometry on B
        wait_b(639, "b639");
        chk("b valid 639", int'(b_val), 1);
        @(negedge clk);
        chk("b valid 640", int'(b_val), 0);
        wait_b(655, "b655");
        chk("b hsync 655", int'(b_hs), 1);
        @(negedge clk);
        chk("b hsync 656", int'(b_hs), 0);
        wait_b(751, "b751");
        chk("b hsync 751", int'(b_hs), 0);
        @(negedge clk);
        chk("b hsync 752", int'(b_hs), 1);
        wait_b(799, "b799");
        chk("b v before wrap", int'(b_v), 0);
        @(negedge clk);
        chk("b v after wrap", int'(b_v), 1);
        chk("b h after wrap", int'(b_h), 0);

        // Frame period on A: 15*12*4 clks
        gap = 0;
        for (int i = 0; i < 3000 && !a_fs; i++) @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3000 && !a_fs; i++) begin
            gap++;
            @(negedge clk);
        end
        chk("a frame period", gap + 1, 720);

        // Score latch at start of vertical blanking
        score0_in = 4'd3;
        score1_in = 4'd1;
        wait_a(0, 6, "blank1");
        chk("score0 latched", int'(a_s0), 3);
        chk("score1 latched", int'(a_s1), 1);
        wait_a(0, 2, "mid frame");
        score0_in = 4'd5;
        wait_a(0, 5, "pre blank");
        chk("score0 held", int'(a_s0), 3);
        wait_a(0, 6, "blank2");
        chk("score0 updated", int'(a_s0), 5);
        chk("score1 held", int'(a_s1), 1);

        // Reset mid-frame
        wait_a(5, 3, "mid reset");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mr h", int'(a_h), 14);
        chk("mr v", int'(a_v), 11);
        chk("mr valid", int'(a_val), 0);
        chk("mr score0", int'(a_s0), 0);
        chk("mr fs", int'(a_fs), 0);

        // Randomized phase against the model
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                score0_in = 4'($urandom_range(0, 15));
                score1_in = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 1999) == 0) begin
                reset_release($urandom_range(1, 3));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Display timing source for the 640x480@60 VGA path. It divides the system clock into a pixel-rate enable, runs the horizontal and vertical counters, and generates hsync, vsync and valid. It also latches the two score digits once per frame so the downstream pixel generator sees stable values for a whole frame. Its outputs (h_cnt, v_cnt, valid, hsync, vsync, score0, score1) drive vga_pixel_gen directly.

Parameters:
CLK_DIV, 4, system clocks per pixel (>=1; 100 MHz / 4 = 25 MHz pixel rate)
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels); H_TOTAL = 800
V_VIS, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = 525

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
score0_in  in  4  right score digit from game logic
score1_in  in  4  left score digit from game logic
h_cnt  out  10  current pixel column, 0..H_TOTAL-1
v_cnt  out  10  current line, 0..V_TOTAL-1
valid  out  1  high while h_cnt<H_VIS and v_cnt<V_VIS
hsync  out  1  active-low horizontal sync
vsync  out  1  active-low vertical sync
score0  out  4  frame-stable copy of score0_in
score1  out  4  frame-stable copy of score1_in
frame_start  out  1  one-clk pulse on the first clk at (0,0)

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low. Every register updates only on a rising clk edge.
- Reset values: div=0, h_cnt=H_TOTAL-1 (799), v_cnt=V_TOTAL-1 (524), valid=0, hsync=1, vsync=1, score0=0, score1=0, frame_start=0.
- Reset mid-frame takes effect on the next edge with the same values. No partial line is completed.
- Pixel tick: div counts 0..CLK_DIV-1 and wraps. tick=1 when div==CLK_DIV-1. With CLK_DIV=1, tick=1 every clk.
- On tick: if h_cnt==H_TOTAL-1, h_cnt<=0; otherwise h_cnt<=h_cnt+1.
- On tick with h_cnt==H_TOTAL-1: if v_cnt==V_TOTAL-1, v_cnt<=0; otherwise v_cnt<=v_cnt+1.
- Without tick, all counters and outputs hold.
- valid, hsync and vsync are registered. They are computed from the next counter values at the same edge, so they always match the h_cnt/v_cnt on the output.
- hsync=0 iff H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC, i.e. 656..751.
- vsync=0 iff V_VIS+V_FP <= v_cnt < V_VIS+V_FP+V_SYNC, i.e. 490..491.
- vsync changes only together with the line wrap (h_cnt -> 0).
- frame_start: set at the edge where the counters move to (0,0); cleared at the following edge. It is exactly one clk wide, regardless of CLK_DIV.
- Score latch: at the edge where the counters move to (h=0, v=V_VIS), i.e. the start of vertical blanking, score0<=score0_in and score1<=score1_in.
- Scores hold at all other times. An input change mid-frame is visible only from the next blanking onward. Values pass through unclamped (0..15).
- Latency: first tick comes CLK_DIV clks after rst_n rises. That tick lands on (0,0) with frame_start=1 and valid=1.

Optional Feature:
FRAME_CNT_EN
- Defined: adds output frame_cnt [15:0]. Reset value 0. Increments on the same edge that sets frame_start. Wraps 65535 -> 0.
- Not defined: the port and its register do not exist. All other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - CNT_W=10;
  - the default H_/V_ timing constants;
  - the derived constants H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END.
- One sub-module, pix_tick_div: parameter CLK_DIV; ports clk, rst_n, tick out. It contains the div counter.
- Counter, sync and latch logic stay in vga_timing_gen.

Test Plan:
1. Hold rst_n=0 for 5 clks, then release, CLK_DIV=4 -> outputs stay at 799/524, valid=0, hsync=vsync=1 through 3 clks. 4th edge: h=0, v=0, valid=1, frame_start=1 for exactly 1 clk. h_cnt=1 after 4 more clks.
2. Line timing -> h_cnt=655: hsync=1. h_cnt=656..751: hsync=0. h_cnt=752: hsync=1. h_cnt=640: valid=0. h 799 -> 0 increments v_cnt by 1.
3. Frame timing -> v_cnt 490..491: vsync=0. v_cnt=480..524: valid=0 for every h. (799,524) -> (0,0) with frame_start pulse. Period = 800*525*4 = 1,680,000 clks.
4. Score latch: score0_in=3, score1_in=1 before frame 1 blanking; set score0_in=5 at v=100 of frame 2 -> score0 stays 3 until the edge entering (0,480) of frame 2, then 5. score1 stays 1.
5. Reset mid-frame: assert rst_n=0 for 1 clk at v=200, h=300 -> next edge: h=799, v=524, valid=0, hsync=vsync=1, score0=score1=0, frame_start=0. Restart follows scenario 1.
6. With FRAME_CNT_EN defined, run 3 full frames after reset -> frame_cnt=3. Preload 65535 via force -> next frame_start wraps it to 0.
